// File: rtl/poly_tone_pkg.sv
// Shared constants, voice state type and the note half-period table for poly_tone.
package poly_tone_pkg;

  localparam int unsigned NUM_VOICES_DEF = 4;
  localparam int unsigned CNT_W_DEF      = 17;
  localparam int unsigned DUR_W_DEF      = 16;
  localparam int unsigned TICK_DIV_DEF   = 100000;

  localparam int unsigned NOTE_W  = 4;
  localparam int unsigned OCT_W   = 2;
  localparam int unsigned TABLE_W = 17;

  typedef enum logic {
    VS_IDLE = 1'b0,
    VS_PLAY = 1'b1
  } voice_state_e;

  // Half-period in clk cycles at octave 0; note 0 is 440 Hz at 100 MHz.
  function automatic logic [TABLE_W-1:0] note_table(input logic [NOTE_W-1:0] note);
    logic [TABLE_W-1:0] h;
    case (note)
      4'd0:    h = 17'd113635;
      4'd1:    h = 17'd107257;
      4'd2:    h = 17'd101237;
      4'd3:    h = 17'd95555;
      4'd4:    h = 17'd90192;
      4'd5:    h = 17'd85130;
      4'd6:    h = 17'd80352;
      4'd7:    h = 17'd75842;
      4'd8:    h = 17'd71585;
      4'd9:    h = 17'd67568;
      4'd10:   h = 17'd63775;
      4'd11:   h = 17'd60196;
      4'd12:   h = 17'd56817;
      4'd13:   h = 17'd53628;
      4'd14:   h = 17'd50618;
      default: h = 17'd47777;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/poly_tone_voice.sv
// One tone voice: IDLE/PLAY FSM, half-period counter driving a square wave,
// and a tick-driven duration counter.
module tone_voice
  import poly_tone_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DUR_W = DUR_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hush_i,
  input  logic             tick_i,
  input  logic             on_i,
  input  logic             off_i,
  input  logic [CNT_W-1:0] half_i,
  input  logic [DUR_W-1:0] dur_i,
  output logic             active_o,
  output logic             square_o
);

  voice_state_e     state_q, state_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic             sq_q, sq_d;
  logic             expire;

  // Last tick of a timed note; remaining == 0 means sustain and never expires.
  assign expire = tick_i && (rem_q == DUR_W'(1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VS_IDLE;
      half_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      sq_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register here samples pre-edge values.
      state_q <= state_d;
      half_q  <= half_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sq_q    <= sq_d;
    end
  end

  // Next state: hush beats note-on, note-on beats note-off and expiry.
  always_comb begin
    state_d = state_q;
    if (state_q == VS_IDLE) begin
      if (on_i) state_d = VS_PLAY;
    end else begin
      if (!on_i && (off_i || expire)) state_d = VS_IDLE;
    end
    if (hush_i) state_d = VS_IDLE;
  end

  // Datapath next values: clear on idle, load on note-on, otherwise run.
  always_comb begin
    // NOTE: hold defaults first so no path leaves a variable unassigned (no latches).
    half_d = half_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    sq_d   = sq_q;
    if (state_d == VS_IDLE) begin
      cnt_d = '0;
      rem_d = '0;
      sq_d  = 1'b0;
    end else if (on_i) begin
      half_d = half_i;
      cnt_d  = '0;
      rem_d  = dur_i;
      sq_d   = 1'b0;
    end else begin
      if (cnt_q == half_q - CNT_W'(1)) begin
        cnt_d = '0;
        sq_d  = ~sq_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (tick_i && (rem_q != '0)) rem_d = rem_q - DUR_W'(1);
    end
  end

  // Outputs come straight from state.
  always_comb begin
    active_o = (state_q == VS_PLAY);
    square_o = sq_q;
  end

endmodule

// File: rtl/poly_tone.sv
// Polyphonic square-wave tone generator: command decode, shared duration
// prescaler, NUM_VOICES tone voices and a first-order delta-sigma mixer.
module poly_tone
  import poly_tone_pkg::*;
#(
  parameter int unsigned NUM_VOICES = NUM_VOICES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned DUR_W      = DUR_W_DEF,
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned VID_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hush,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [VID_W-1:0]      cmd_voice,
  input  logic                  cmd_off,
  input  logic [NOTE_W-1:0]     cmd_note,
  input  logic [OCT_W-1:0]      cmd_oct,
  input  logic [DUR_W-1:0]      cmd_dur,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [NUM_VOICES-1:0] square_out,
  output logic                  speaker
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ACC_W = $clog2(NUM_VOICES) + 1;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned LVL_W = $clog2(NUM_VOICES + 1);

  logic                  ready_q, ready_d;
  logic [PRE_W-1:0]      presc_q, presc_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic                  spk_q, spk_d;
  logic                  tick;
  logic                  accept;
  logic [NUM_VOICES-1:0] on_strobe, off_strobe;
  logic [CNT_W-1:0]      cmd_half;
  logic [LVL_W-1:0]      level;
  logic [SUM_W-1:0]      sum;

  // Ready goes high on the first edge after reset release; hush gates it.
  assign ready_d   = 1'b1;
  assign cmd_ready = ready_q & ~hush;
  assign accept    = cmd_valid & cmd_ready;
  assign speaker   = spk_q;

  // Octave shift halves the half-period per step.
  assign cmd_half = CNT_W'(note_table(cmd_note) >> cmd_oct);

  // Route the accepted command to its voice; indices past the last voice fall through.
  always_comb begin
    on_strobe  = '0;
    off_strobe = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      if (accept && (int'(cmd_voice) == i)) begin
        on_strobe[i]  = ~cmd_off;
        off_strobe[i] = cmd_off;
      end
    end
  end

  // Free-running duration prescaler; tick marks the wrap cycle.
  assign tick = (presc_q == PRE_W'(TICK_DIV - 1));
  always_comb begin
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
  end

  for (genvar g = 0; g < int'(NUM_VOICES); g++) begin : g_voice
    tone_voice #(
      .CNT_W (CNT_W),
      .DUR_W (DUR_W)
    ) u_voice (
      .clk      (clk),
      .rst_n    (rst_n),
      .hush_i   (hush),
      .tick_i   (tick),
      .on_i     (on_strobe[g]),
      .off_i    (off_strobe[g]),
      .half_i   (cmd_half),
      .dur_i    (cmd_dur),
      .active_o (voice_active[g]),
      .square_o (square_out[g])
    );
  end

  // Number of voices whose square is currently high.
  always_comb begin
    level = '0;
    for (int i = 0; i < int'(NUM_VOICES); i++) begin
      level = level + LVL_W'(square_out[i]);
    end
  end

  // Delta-sigma: emit a 1 each time the accumulated level crosses NUM_VOICES.
  always_comb begin
    sum   = SUM_W'(acc_q) + SUM_W'(level);
    acc_d = ACC_W'(sum);
    spk_d = 1'b0;
    if (hush) begin
      acc_d = '0;
    end else if (sum >= SUM_W'(NUM_VOICES)) begin
      spk_d = 1'b1;
      acc_d = ACC_W'(sum - SUM_W'(NUM_VOICES));
    end
  end

  // Top-level registers: ready flag, prescaler and mixer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      presc_q <= '0;
      acc_q   <= '0;
      spk_q   <= 1'b0;
    end else begin
      ready_q <= ready_d;
      presc_q <= presc_d;
      acc_q   <= acc_d;
      spk_q   <= spk_d;
    end
  end

endmodule

// File: tb/tb_poly_tone.sv
// Self-checking bench for poly_tone: directed scenarios plus random commands,
// compared every cycle against a time-based behavioural model.
module tb_poly_tone;

  localparam int unsigned NV = 4;
  localparam int unsigned CW = 17;
  localparam int unsigned DW = 16;
  localparam int unsigned TD = 100;
  localparam int unsigned VW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          hush = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_off = 1'b0;
  logic [VW-1:0] cmd_voice = '0;
  logic [3:0]    cmd_note = '0;
  logic [1:0]    cmd_oct = '0;
  logic [DW-1:0] cmd_dur = '0;
  logic          cmd_ready;
  logic [NV-1:0] voice_active;
  logic [NV-1:0] square_out;
  logic          speaker;

  always #5 clk = ~clk;

  poly_tone #(
    .NUM_VOICES (NV),
    .CNT_W      (CW),
    .DUR_W      (DW),
    .TICK_DIV   (TD),
    .VID_W      (VW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hush         (hush),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_voice    (cmd_voice),
    .cmd_off      (cmd_off),
    .cmd_note     (cmd_note),
    .cmd_oct      (cmd_oct),
    .cmd_dur      (cmd_dur),
    .voice_active (voice_active),
    .square_out   (square_out),
    .speaker      (speaker)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: each voice is a start edge, half-period and end edge;
  // the mixer is a running level total whose multiples of NV produce pulses.
  int note_tab [16] = '{113635, 107257, 101237, 95555, 90192, 85130, 80352, 75842,
                        71585, 67568, 63775, 60196, 56817, 53628, 50618, 47777};
  int edge_n;
  bit released;
  bit m_act [NV];
  bit m_sq [NV];
  int m_start [NV];
  int m_half [NV];
  int m_end [NV];
  int total;
  bit m_spk;
  bit m_accept;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, edge_n, got, exp);
    end
  endtask

  function automatic void model_reset();
    edge_n   = 0;
    released = 1'b0;
    total    = 0;
    m_spk    = 1'b0;
    m_accept = 1'b0;
    for (int i = 0; i < int'(NV); i++) begin
      m_act[i] = 1'b0;
      m_sq[i]  = 1'b0;
      m_end[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    int lvl;
    int prev;
    bit rdy;
    lvl = 0;
    for (int i = 0; i < int'(NV); i++) lvl += int'(m_sq[i]);
    rdy      = released && !hush;
    m_accept = cmd_valid && rdy;
    if (hush) begin
      total = 0;
      m_spk = 1'b0;
    end else begin
      prev  = total;
      total = total + lvl;
      m_spk = (total / int'(NV)) != (prev / int'(NV));
    end
    for (int i = 0; i < int'(NV); i++) begin
      bit hit;
      hit = m_accept && (int'(cmd_voice) == i);
      if (hush) begin
        m_act[i] = 1'b0;
      end else if (hit && !cmd_off) begin
        m_act[i]   = 1'b1;
        m_start[i] = edge_n;
        m_half[i]  = note_tab[cmd_note] >> cmd_oct;
        m_end[i]   = (cmd_dur == 0) ? 0 : ((edge_n / int'(TD)) + int'(cmd_dur)) * int'(TD);
      end else if (m_act[i]) begin
        if (hit && cmd_off) m_act[i] = 1'b0;
        else if (m_end[i] != 0 && edge_n == m_end[i]) m_act[i] = 1'b0;
      end
      m_sq[i] = m_act[i] ? bit'(((edge_n - m_start[i]) / m_half[i]) % 2) : 1'b0;
    end
    released = 1'b1;
  endfunction

  task automatic compare();
    logic [NV-1:0] exp_act;
    logic [NV-1:0] exp_sq;
    for (int i = 0; i < int'(NV); i++) begin
      exp_act[i] = m_act[i];
      exp_sq[i]  = m_sq[i];
    end
    check("voice_active", 32'(voice_active), 32'(exp_act));
    check("square_out", 32'(square_out), 32'(exp_sq));
    check("speaker", 32'(speaker), 32'(m_spk));
    check("cmd_ready", 32'(cmd_ready), 32'(released && !hush));
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    compare();
    if (failures >= 50) begin
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int v, input bit off, input int note, input int oct, input int dur);
    int budget;
    cmd_valid = 1'b1;
    cmd_voice = VW'(v);
    cmd_off   = off;
    cmd_note  = 4'(note);
    cmd_oct   = 2'(oct);
    cmd_dur   = DW'(dur);
    budget    = 0;
    do begin
      step();
      budget++;
    end while (!m_accept && budget < 1000);
    check("cmd_accept", 32'(m_accept), 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int hush_left;
    int budget;

    // Reset state.
    #1 rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_voice_active", 32'(voice_active), 32'd0);
    check("rst_square_out", 32'(square_out), 32'd0);
    check("rst_speaker", 32'(speaker), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    release_reset();
    run(3);

    // Sustained note on voice 0, timed note on voice 1 (H = 5972, dur 5).
    send(0, 1'b0, 0, 3, 0);
    send(1, 1'b0, 15, 3, 5);
    check("v1_playing", 32'(voice_active[1]), 32'd1);
    run(520);
    check("v1_expired", 32'(voice_active[1]), 32'd0);
    check("v0_sustained", 32'(voice_active[0]), 32'd1);

    // All four voices playing the same pitch, then a 2-of-4 mix.
    send(0, 1'b0, 0, 3, 0);
    send(1, 1'b0, 0, 3, 0);
    send(2, 1'b0, 0, 3, 0);
    send(3, 1'b0, 0, 3, 0);
    run(9000);
    send(2, 1'b1, 0, 0, 0);
    send(3, 1'b1, 0, 0, 0);
    run(6000);

    // Hush mid-note with a command held valid throughout.
    hush = 1'b1;
    cmd_valid = 1'b1;
    cmd_voice = VW'(0);
    cmd_off   = 1'b0;
    cmd_note  = 4'd5;
    cmd_oct   = 2'd3;
    cmd_dur   = DW'(0);
    step();
    check("hush_all_idle", 32'(voice_active), 32'd0);
    run(20);
    check("hush_not_taken", 32'(m_accept), 32'd0);
    hush = 1'b0;
    step();
    check("after_hush_taken", 32'(m_accept), 32'd1);
    cmd_valid = 1'b0;
    run(50);

    // Retrigger voice 2 on the same edge as its expiry tick.
    send(2, 1'b0, 3, 3, 1);
    budget = 0;
    while ((edge_n % int'(TD)) != int'(TD) - 1 && budget < 2 * int'(TD)) begin
      step();
      budget++;
    end
    cmd_valid = 1'b1;
    cmd_voice = VW'(2);
    cmd_off   = 1'b0;
    cmd_note  = 4'd7;
    cmd_oct   = 2'd2;
    cmd_dur   = DW'(3);
    step();
    cmd_valid = 1'b0;
    check("retrigger_edge_is_tick", 32'(edge_n % int'(TD)), 32'd0);
    check("retrigger_active", 32'(voice_active[2]), 32'd1);
    run(4 * int'(TD));
    check("retrigger_expired", 32'(voice_active[2]), 32'd0);

    // Out-of-range voice and note-off to an idle voice are consumed silently.
    send(5, 1'b0, 1, 3, 0);
    send(7, 1'b0, 2, 3, 0);
    send(2, 1'b1, 0, 0, 0);
    run(5);
    check("ignored_v2_idle", 32'(voice_active[2]), 32'd0);
    check("ignored_v3_idle", 32'(voice_active[3]), 32'd0);

    // Note-off to a playing voice.
    send(0, 1'b1, 0, 0, 0);
    check("noteoff_active", 32'(voice_active[0]), 32'd0);
    check("noteoff_square", 32'(square_out[0]), 32'd0);

    // Random commands and hush pulses.
    hush_left = 0;
    for (int c = 0; c < 35000; c++) begin
      if (!cmd_valid && $urandom_range(0, 149) == 0) begin
        cmd_valid = 1'b1;
        cmd_voice = VW'($urandom_range(0, 7));
        cmd_off   = ($urandom_range(0, 4) == 0);
        cmd_note  = 4'($urandom);
        cmd_oct   = 2'($urandom_range(1, 3));
        cmd_dur   = DW'($urandom_range(0, 40));
      end
      if (hush_left == 0 && $urandom_range(0, 3999) == 0) hush_left = $urandom_range(1, 30);
      hush = (hush_left > 0);
      if (hush_left > 0) hush_left--;
      step();
      if (m_accept) cmd_valid = 1'b0;
    end
    hush = 1'b0;
    cmd_valid = 1'b0;
    run(5);

    // Asynchronous reset in the middle of play.
    send(0, 1'b0, 0, 3, 0);
    send(1, 1'b0, 4, 2, 0);
    run(3000);
    #2 rst_n = 1'b0;
    #1;
    check("arst_voice_active", 32'(voice_active), 32'd0);
    check("arst_square_out", 32'(square_out), 32'd0);
    check("arst_speaker", 32'(speaker), 32'd0);
    check("arst_cmd_ready", 32'(cmd_ready), 32'd0);
    release_reset();
    step();
    send(3, 1'b0, 15, 3, 2);
    run(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/poly_tone.md
# poly_tone

Parametrised polyphonic square-wave tone generator for the audio output path. It holds NUM_VOICES independent voices, each programmed through a valid/ready command port with note, octave and duration. All voices are mixed into one 1-bit speaker stream by a first-order delta-sigma modulator. It replaces the single-voice, note-held-on-switches generator with timed notes, octave shift, explicit note-off and a global hush.

## Interface
- NUM_VOICES, 4: number of independent voices (1..16)
- CNT_W, 17: half-period counter width; must hold the largest table value (113635)
- DUR_W, 16: note duration field width, in ticks
- TICK_DIV, 100000: clk cycles per duration tick (1 ms at 100 MHz)
- VID_W, $clog2(NUM_VOICES) (minimum 1): voice index width
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- hush  in  1  global mute: silences and idles all voices while high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted; equals rst_n-released AND !hush
- cmd_voice  in  VID_W  target voice index
- cmd_off  in  1  1 = note-off, 0 = note-on
- cmd_note  in  4  note code 0..15
- cmd_oct  in  2  octave shift 0..3
- cmd_dur  in  DUR_W  duration in ticks; 0 = sustain until note-off or hush
- voice_active  out  NUM_VOICES  per-voice PLAY flag
- square_out  out  NUM_VOICES  per-voice raw square wave
- speaker  out  1  mixed delta-sigma output

## Operation
- A command is accepted on a rising edge with cmd_valid && cmd_ready.
- While hush is high, cmd_ready = 0 and commands are not consumed.
- An accepted command with cmd_voice >= NUM_VOICES is consumed and ignored.
- Half-period H = NOTE_TABLE[cmd_note] >> cmd_oct, in clk cycles, where NOTE_TABLE = 113635, 107257, 101237, 95555, 90192, 85130, 80352, 75842, 71585, 67568, 63775, 60196, 56817, 53628, 50618, 47777. Note 0, octave 0 gives 440 Hz.
- Each voice runs a two-state FSM, IDLE and PLAY:
  - IDLE -> PLAY on a note-on: latch H; count <= 0; square <= 0; remaining <= cmd_dur.
  - PLAY -> PLAY on a note-on to the same voice: retrigger with the same loads.
  - PLAY -> IDLE on a note-off, duration expiry, or hush. On entering IDLE, square <= 0 and count <= 0.
  - A note-off to an IDLE voice has no effect.
- Tone generation in PLAY: count increments every cycle. When count == H-1, count <= 0 and square toggles.
- Duration: a shared prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick at the wrap. This prescaler is free-running and is not restarted by commands.
  - In PLAY with remaining != 0, each tick decrements remaining.
  - A tick with remaining == 1 causes expiry (-> IDLE).
  - Audible length is between (dur-1)*TICK_DIV+1 and dur*TICK_DIV cycles.
- Mixer:
  - level = popcount(square_out).
  - acc (width $clog2(NUM_VOICES)+1) updates each cycle. If acc+level >= NUM_VOICES: speaker <= 1 and acc <= acc+level-NUM_VOICES. Otherwise speaker <= 0 and acc <= acc+level.
  - The speaker pulse density equals level/NUM_VOICES.
- Hush forces every voice to IDLE and keeps acc at 0.

## Timing
- Reset values: voice_active = 0, square_out = 0, speaker = 0, cmd_ready = 0; all counters, prescaler and acc = 0.
- cmd_ready rises on the first clk edge after rst_n deasserts, unless hush is high.
- Assertion of rst_n mid-note clears all state immediately, asynchronously.
- Accept at edge k: voice_active rises at edge k. The first square rise is at edge k+H; the square then toggles every H cycles.
- speaker is registered, one cycle behind square_out.
- Note-off accepted at edge k: voice_active and square_out are 0 after edge k.
- Simultaneous events on the same voice and edge:
  - A note-on beats expiry: the voice retriggers.
  - Hush beats everything.
- Commands to different voices never interact. Only one command is accepted per cycle.
- Prescaler wrap: the tick is asserted when the prescaler equals TICK_DIV-1, and the prescaler then returns to 0.

## Structure
- The package poly_tone_pkg holds:
  - the NOTE_TABLE constant function (17-bit, zero-extended to CNT_W)
  - the voice state typedef (IDLE, PLAY)
  - the default parameter constants
- Sub-module tone_voice contains one voice (FSM, half-period counter, duration counter). It is generated NUM_VOICES times and shares tick and the decoded command strobes.
- The top level contains the command decode, prescaler, popcount and delta-sigma mixer.

## Test plan
- Reset, then note-on voice 0, note 0, oct 0, dur 0 → square_out[0] toggles every 113635 cycles; voice_active = 0001.
- Note-on voice 1, note 15, oct 3, TICK_DIV = 100, dur 5 → H = 5972; voice 1 goes IDLE between 401 and 500 cycles after accept.
- Voices 0..3 all playing, all square high → speaker constant 1. Two of four high → speaker alternates with 50% density.
- Raise hush mid-note → all outputs 0 next edge; cmd_ready = 0; a command held valid during hush is accepted only after hush falls.
- Retrigger voice 2 on the same edge as its expiry tick → voice stays active with count reset and new H.
- cmd_voice = 5 with NUM_VOICES = 4, plus note-off to an idle voice → command consumed, no output change. Assert rst_n mid-play → every output 0 immediately.
